// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM stage: byte lanes, write-back select encoding
// and the syscall exit code.
package mem_stage_pkg;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

  typedef enum logic [1:0] {
    WB_SEL_RAM = 2'd0,
    WB_SEL_LO  = 2'd1,
    WB_SEL_ALU = 2'd2
  } wb_sel_e;

  localparam logic [31:0] SYSCALL_EXIT = 32'd10;

  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/mem_stage_data_ram.sv
// Generic data RAM: asynchronous read, synchronous write with one write
// enable per byte lane. No reset; contents are undefined until written.
module data_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [3:0]            we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data RAM access, LO register, syscall halt/display
// latches and a committed RAM access counter. Adds no latency.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] MEM_PC,
  input  logic                  MEM_writetolo,
  input  logic                  MEM_regwe,
  input  logic                  MEM_ramtoreg,
  input  logic                  MEM_lotoreg,
  input  logic                  MEM_syscall,
  input  logic                  MEM_ramwe,
  input  logic                  MEM_rambyte,
  input  logic [DATA_WIDTH-1:0] MEM_result,
  input  logic [4:0]            MEM_RW,
  input  logic [DATA_WIDTH-1:0] MEM_r2,
  input  logic                  syscall_halt,
  output logic [DATA_WIDTH-1:0] WB_data,
  output logic                  WB_regwe,
  output logic [4:0]            WB_RW,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic                  halted,
  output logic [DATA_WIDTH-1:0] display,
  output logic [DATA_WIDTH-1:0] halt_pc,
  output logic [31:0]           ram_access_count
);

  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic                  halted_q, halted_d;
  logic [DATA_WIDTH-1:0] display_q, display_d;
  logic [DATA_WIDTH-1:0] haltPc_q, haltPc_d;
  logic [31:0]           accessCount_q, accessCount_d;

  logic                  active;
  logic [1:0]            lane;
  logic [ADDR_WIDTH-1:0] wordIdx;
  logic [3:0]            ramWe;
  logic [31:0]           ramWdata;
  logic [31:0]           ramRdata;
  logic [7:0]            loadByte;
  logic [DATA_WIDTH-1:0] loadData;
  wb_sel_e               wbSel;
  logic                  unused_addr_bits;

  assign active   = en && !halted_q;
  assign lane     = MEM_result[1:0];
  assign wordIdx  = MEM_result[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^MEM_result[DATA_WIDTH-1:ADDR_WIDTH+2];

  // The RAM itself is ungated, so stall and halt qualification happen here.
  assign ramWe    = (active && MEM_ramwe) ? (MEM_rambyte ? lane_mask(lane) : 4'hF) : 4'h0;
  assign ramWdata = MEM_rambyte ? {4{MEM_r2[7:0]}} : MEM_r2;

  data_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_data_ram (
    .clk     (clk),
    .we_i    (ramWe),
    .addr_i  (wordIdx),
    .wdata_i (ramWdata),
    .rdata_o (ramRdata)
  );

  always_comb begin
    loadByte = ramRdata[7:0];
    case (lane)
      LANE1:   loadByte = ramRdata[15:8];
      LANE2:   loadByte = ramRdata[23:16];
      LANE3:   loadByte = ramRdata[31:24];
      default: loadByte = ramRdata[7:0];
    endcase
  end

  assign loadData = MEM_rambyte ? {24'd0, loadByte} : ramRdata;

  always_comb begin
    wbSel = WB_SEL_ALU;
    if (MEM_ramtoreg)     wbSel = WB_SEL_RAM;
    else if (MEM_lotoreg) wbSel = WB_SEL_LO;
  end

  // WB_data reads the registered LO, so writetolo+lotoreg returns the old value.
  always_comb begin
    WB_data = MEM_result;
    case (wbSel)
      WB_SEL_RAM: WB_data = loadData;
      WB_SEL_LO:  WB_data = lo_q;
      default:    WB_data = MEM_result;
    endcase
  end

  assign fwd_data = WB_data;
  assign WB_regwe = MEM_regwe && !halted_q;
  assign WB_RW    = MEM_RW;

  always_comb begin
    lo_d          = lo_q;
    halted_d      = halted_q;
    display_d     = display_q;
    haltPc_d      = haltPc_q;
    accessCount_d = accessCount_q;
    if (active) begin
      if (MEM_writetolo) lo_d = MEM_result;
      if (MEM_syscall) begin
        if (syscall_halt) begin
          halted_d = 1'b1;
          haltPc_d = MEM_PC;
        end else begin
          display_d = MEM_r2;
        end
      end
      if (MEM_ramtoreg || MEM_ramwe) accessCount_d = accessCount_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_q          <= '0;
      halted_q      <= 1'b0;
      display_q     <= '0;
      haltPc_q      <= '0;
      accessCount_q <= '0;
    end else begin
      lo_q          <= lo_d;
      halted_q      <= halted_d;
      display_q     <= display_d;
      haltPc_q      <= haltPc_d;
      accessCount_q <= accessCount_d;
    end
  end

  assign halted           = halted_q;
  assign display          = display_q;
  assign halt_pc          = haltPc_q;
  assign ram_access_count = accessCount_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage pipeline; consumes the EX/MEM pipeline register outputs and produces write-back data for the MEM/WB register and the forwarding network.
- Contains the data RAM (word and byte access), the LO register, the syscall halt/display latches, and a RAM access counter.
- Data RAM read is asynchronous: load data is valid in the same cycle. The stage adds no latency; all state updates occur on the rising clk edge.

Parameters:
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- ADDR_WIDTH, 10, word-address bits; RAM depth is 2^ADDR_WIDTH words.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  stage enable; 0 means the pipeline is stalled.
- MEM_PC  in  DATA_WIDTH  PC of the instruction in MEM.
- MEM_writetolo  in  1  write MEM_result into LO.
- MEM_regwe  in  1  register-file write enable of the instruction.
- MEM_ramtoreg  in  1  write-back selects RAM load data.
- MEM_lotoreg  in  1  write-back selects LO.
- MEM_syscall  in  1  instruction is a syscall.
- MEM_ramwe  in  1  store.
- MEM_rambyte  in  1  1 means byte access; 0 means word access.
- MEM_result  in  DATA_WIDTH  ALU result; used as the byte address.
- MEM_RW  in  5  destination register number.
- MEM_r2  in  DATA_WIDTH  store data; also syscall argument ($a0).
- syscall_halt  in  1  1 means the syscall in MEM is an exit ($v0==10).
- WB_data  out  DATA_WIDTH  selected write-back value.
- WB_regwe  out  1  MEM_regwe gated by the halted state.
- WB_RW  out  5  passthrough of MEM_RW.
- fwd_data  out  DATA_WIDTH  equals WB_data; drives EX-stage forwarding.
- halted  out  1  sticky halt flag.
- display  out  DATA_WIDTH  last non-exit syscall argument.
- halt_pc  out  DATA_WIDTH  PC of the exit syscall.
- ram_access_count  out  32  number of committed loads plus stores.

Behaviour:
- Reset (rst=0, asynchronous): LO, display, halt_pc, ram_access_count and halted all go to 0. RAM contents are not reset.
- Addressing: word index = MEM_result[ADDR_WIDTH+1:2]. Higher address bits are ignored, so accesses alias. Lane = MEM_result[1:0], little-endian (lane 0 = bits 7:0).
- Word access ignores lane bits; there is no misalignment trap.
- Load data:
  - Word access: the RAM word.
  - Byte access: the selected lane, zero-extended to 32 bits.
- Write-back mux priority: MEM_ramtoreg first, then MEM_lotoreg, then MEM_result.
- Store on rising edge when en=1, MEM_ramwe=1 and halted=0:
  - Word store writes MEM_r2.
  - Byte store writes MEM_r2[7:0] into the addressed lane only; the other lanes are unchanged.
- Load-after-store to the same address in consecutive cycles returns the new data, because the store has committed by the next cycle.
- LO: loaded with MEM_result when en=1, MEM_writetolo=1 and halted=0.
  - If MEM_writetolo and MEM_lotoreg are both set in the same instruction, WB_data returns the old LO.
- Syscall, when en=1, MEM_syscall=1 and halted=0:
  - syscall_halt=1: halted is set to 1 and halt_pc is set to MEM_PC.
  - syscall_halt=0: display is set to MEM_r2.
- halted remains set until rst. While halted, no RAM, LO, display or counter updates occur, and WB_regwe is 0.
- ram_access_count increments by 1 per committed load (MEM_ramtoreg) or store, when en=1 and halted=0. It wraps from 0xFFFFFFFF to 0.
- en=0: all state holds; combinational outputs still reflect the inputs.
- Reset asserted mid-store: the RAM write is not guaranteed; registers clear immediately.

Decomposition:
- Shared package holds:
  - Byte-lane constants (LANE0..LANE3).
  - Write-back select encoding (WB_SEL_RAM, WB_SEL_LO, WB_SEL_ALU).
  - The SYSCALL_EXIT code (10).
- One sub-module, data_ram: asynchronous-read, synchronous-write, 4 byte-lane write enables, parameterised by ADDR_WIDTH. The data_ram is generic and has no halt or en gating; the stage qualifies the write enables.

Test Plan:
- Word store/load: store 0xDEADBEEF to address 0x10, then word-load 0x10 -> WB_data=0xDEADBEEF, ram_access_count=2.
- Byte store/load: byte-store 0xAA to address 0x11 over word 0x11223344 -> word load returns 0x1122AA44; byte load at 0x11 returns 0x000000AA.
- LO path:
  - writetolo with result=5 -> next-cycle lotoreg gives WB_data=5.
  - writetolo=1 and lotoreg=1 together -> WB_data is the previous LO.
- Syscall exit:
  - syscall with syscall_halt=0 and r2=42 -> display=42.
  - Then exit syscall at PC=0x3C -> halted=1, halt_pc=0x3C.
  - A following store leaves RAM unchanged and WB_regwe=0.
- Stall and reset: store with en=0 -> RAM and counter unchanged. Assert rst low between clock edges -> halted, LO and counter read 0 immediately.
- Aliasing: store 0x1 to word index 0, then load address 4<<ADDR_WIDTH -> WB_data=0x1.
